reg_wb_sched: RTL and testbench
===============================

Name: reg_wb_sched

Overview:
- Write-back scheduler for the 16x8 register file's single write port.
- Two requesters share the port:
  - ALU result path (requester 0).
  - Memory-load path (requester 1).
- Each requester has a one-entry holding slot with a valid/ready handshake.
- A round-robin arbiter with same-address age ordering drains the slots into registered wr_en/wr_addr/dat_in outputs.
- A pending-write mask lets decode stall reads of registers with writes still in flight.

Parameters:
- pw, 4, register address width (16 registers).
- dw, 8, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- start  in  1  synchronous active-high reset.
- alu_vld  in  1  ALU write-back request valid.
- alu_addr  in  pw  ALU destination register.
- alu_dat  in  dw  ALU result.
- alu_rdy  out  1  ALU slot can accept this cycle.
- mem_vld  in  1  load write-back request valid.
- mem_addr  in  pw  load destination register.
- mem_dat  in  dw  load data.
- mem_rdy  out  1  load slot can accept this cycle.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  pw  register-file write address (registered).
- dat_in  out  dw  register-file write data (registered).
- pend_mask  out  2**pw  bit i=1 while any write to Ri is held or presented.
- sched_idle  out  1  both slots and output stage empty.

Behaviour:
- Reset: clk and start are the only clock and reset; reset is synchronous and active-high.
  - start=1 at a posedge clears both slots, wr_en, wr_addr, dat_in, the age bit, and the RR pointer (RR pointer favours ALU).
  - In-flight writes are dropped.
  - During start: alu_rdy=mem_rdy=0, pend_mask=0, sched_idle=1.
- Accept: at a posedge with X_vld && X_rdy, the slot loads {addr, dat} and becomes occupied.
  - vld with rdy=0 is ignored; the requester must hold its request.
- Ready (combinational): X_rdy = !start && (slot empty || slot granted this cycle).
  - Drain and refill in the same cycle is legal.
- Grant (combinational from slot state):
  - Only one slot occupied: grant it.
  - Both occupied, same addr: grant the older slot.
    - Age bit records which slot loaded first.
    - Simultaneous load: ALU counts as older.
  - Both occupied, different addr: grant per RR pointer, then move the pointer to the other requester.
  - A single-occupant grant also moves the pointer to the other requester.
- Output stage: at each posedge, the granted slot is cleared and copied to wr_addr/dat_in with wr_en=1.
  - If no grant, wr_en=0 and wr_addr/dat_in hold their previous values.
- Latency: request accepted at edge k, wr_en high during cycle k+1..k+2, register file commits at edge k+2.
  - Sustained throughput is one write per cycle.
- pend_mask: OR of the one-hot decode of each occupied slot's addr and of wr_addr when wr_en=1.
  - It is combinational from registered state only, never from vld inputs.
- sched_idle = no occupied slot && !wr_en.
- Status register (R3):
  - Writes to addr 3 are scheduled like any other.
  - The register file gives wr_en priority over the flag update, so the scheduler needs no special case.
- Starvation bound: with both requesters saturated at different addrs, grants alternate strictly.
  - No requester waits more than one cycle for grant once its slot is occupied.
- start mid-operation: a write presented on wr_en in the cycle start is sampled still commits in the register file that edge. Nothing queued survives.

Decomposition:
- Package reg_wb_pkg holds:
  - REQ_ALU=0, REQ_MEM=1, NUM_REG=16, STATUS_ADDR=3.
  - typedef struct packed {logic[pw-1:0] addr; logic[dw-1:0] dat;} wb_req_t.
- Sub-module wb_slot: one-entry holding register with load/clear/occupied, instantiated twice.
- Arbiter, age bit and output stage live in the top module.

Test Plan:
- Single ALU write: alu_vld=1, addr=5, dat=0x3C for one cycle.
  - wr_en=1, wr_addr=5, dat_in=0x3C exactly two edges later.
  - pend_mask[5] high from the accept edge until wr_en drops.
- Simultaneous, different addrs: ALU (R1,0x11) and MEM (R2,0x22) in the same cycle.
  - Writes R1 then R2 on consecutive cycles; both rdy re-assert so back-to-back traffic sustains one write per cycle, alternating.
- Simultaneous, same addr: MEM (R4,0xAA) accepted one cycle before ALU (R4,0xBB), with the RR pointer favouring ALU.
  - 0xAA written first, then 0xBB; final R4=0xBB.
- Back-pressure: hold mem_vld=1 for 10 cycles with the ALU also saturated (distinct addrs).
  - mem_rdy toggles so MEM gets exactly 5 grants and ALU 5; no request is lost or duplicated.
- Reset mid-flight: assert start with both slots occupied and wr_en=1.
  - Next cycle wr_en=0, pend_mask=0, sched_idle=1.
  - Queued writes never appear; the arbiter favours ALU afterwards.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file write-back scheduler.
// Holds the requester indices, register-file geometry and the
// request record carried by each holding slot.
package reg_wb_pkg;

    localparam int unsigned PW          = 4;
    localparam int unsigned DW          = 8;
    localparam int unsigned NUM_REG     = 16;
    localparam int unsigned STATUS_ADDR = 3;
    localparam int unsigned REQ_ALU     = 0;
    localparam int unsigned REQ_MEM     = 1;

    // Requester selector, used for the round-robin pointer.
    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } req_sel_t;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [DW-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a write-back request.
// Ports:
//   clk      clock
//   start    synchronous active-high reset, empties the slot
//   load     capture req_in and mark occupied
//   clear    release the slot (ignored when load is also set)
//   req_in   incoming request record
//   req      held request record
//   occupied slot holds a valid request
module wb_slot
    import reg_wb_pkg::*;
(
    input  logic    clk,
    input  logic    start,
    input  logic    load,
    input  logic    clear,
    input  wb_req_t req_in,
    output wb_req_t req,
    output logic    occupied
);

    always_ff @(posedge clk) begin
        if (start) begin
            occupied <= 1'b0;
            req      <= '0;
        end else if (load) begin
            // Load wins over clear so a drain and refill in one cycle keeps the slot full.
            occupied <= 1'b1;
            req      <= req_in;
        end else if (clear) begin
            occupied <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_wb_sched.sv
// Write-back scheduler for the 16x8 register file's single write port.
// The ALU and memory-load paths each own a one-entry slot; a round-robin
// arbiter with same-address age ordering drains them into registered
// wr_en/wr_addr/dat_in.
// Ports:
//   clk, start            clock and synchronous active-high reset
//   alu_vld/addr/dat/rdy  ALU write-back request handshake
//   mem_vld/addr/dat/rdy  load write-back request handshake
//   wr_en/wr_addr/dat_in  registered register-file write port
//   pend_mask             registers with a write held or presented
//   sched_idle            both slots and the output stage are empty
module reg_wb_sched
    import reg_wb_pkg::*;
#(
    parameter int unsigned pw = PW,
    parameter int unsigned dw = DW
) (
    input  logic               clk,
    input  logic               start,
    input  logic               alu_vld,
    input  logic [pw-1:0]      alu_addr,
    input  logic [dw-1:0]      alu_dat,
    output logic               alu_rdy,
    input  logic               mem_vld,
    input  logic [pw-1:0]      mem_addr,
    input  logic [dw-1:0]      mem_dat,
    output logic               mem_rdy,
    output logic               wr_en,
    output logic [pw-1:0]      wr_addr,
    output logic [dw-1:0]      dat_in,
    output logic [(1<<pw)-1:0] pend_mask,
    output logic               sched_idle
);

    wb_req_t  alu_q, mem_q;
    logic     alu_occ, mem_occ;
    logic     alu_load, mem_load;
    logic     gnt_alu, gnt_mem;
    logic     alu_stay, mem_stay;
    logic     same_addr;
    logic     mem_older;
    req_sel_t rr_q;

    wb_slot u_alu_slot (
        .clk      (clk),
        .start    (start),
        .load     (alu_load),
        .clear    (gnt_alu),
        .req_in   ('{addr: alu_addr, dat: alu_dat}),
        .req      (alu_q),
        .occupied (alu_occ)
    );

    wb_slot u_mem_slot (
        .clk      (clk),
        .start    (start),
        .load     (mem_load),
        .clear    (gnt_mem),
        .req_in   ('{addr: mem_addr, dat: mem_dat}),
        .req      (mem_q),
        .occupied (mem_occ)
    );

    assign same_addr = alu_occ && mem_occ && (alu_q.addr == mem_q.addr);

    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if (alu_occ && mem_occ) begin
            // Same destination must commit in arrival order; otherwise round-robin.
            if (same_addr) begin
                gnt_mem = mem_older;
                gnt_alu = !mem_older;
            end else if (rr_q == SEL_MEM) begin
                gnt_mem = 1'b1;
            end else begin
                gnt_alu = 1'b1;
            end
        end else begin
            gnt_alu = alu_occ;
            gnt_mem = mem_occ;
        end
    end

    assign alu_rdy  = !start && (!alu_occ || gnt_alu);
    assign mem_rdy  = !start && (!mem_occ || gnt_mem);
    assign alu_load = alu_vld && alu_rdy;
    assign mem_load = mem_vld && mem_rdy;
    assign alu_stay = alu_occ && !gnt_alu;
    assign mem_stay = mem_occ && !gnt_mem;

    always_ff @(posedge clk) begin
        if (start) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            dat_in    <= '0;
            rr_q      <= SEL_ALU;
            mem_older <= 1'b0;
        end else begin
            wr_en <= gnt_alu || gnt_mem;
            if (gnt_alu) begin
                wr_addr <= alu_q.addr;
                dat_in  <= alu_q.dat;
            end else if (gnt_mem) begin
                wr_addr <= mem_q.addr;
                dat_in  <= mem_q.dat;
            end
            if ((gnt_alu || gnt_mem) && !same_addr) begin
                rr_q <= gnt_alu ? SEL_MEM : SEL_ALU;
            end
            // Age only matters once both slots are full; record it whenever that can arise.
            if (alu_load && mem_load) begin
                mem_older <= 1'b0;
            end else if (alu_load && mem_stay) begin
                mem_older <= 1'b1;
            end else if (mem_load && alu_stay) begin
                mem_older <= 1'b0;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        if (!start) begin
            if (alu_occ) pend_mask[alu_q.addr] = 1'b1;
            if (mem_occ) pend_mask[mem_q.addr] = 1'b1;
            if (wr_en)   pend_mask[wr_addr]    = 1'b1;
        end
    end

    assign sched_idle = start || (!alu_occ && !mem_occ && !wr_en);

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed bench for reg_wb_sched: single write, simultaneous requests,
// same-address ordering, status register, saturated back-pressure and
// reset while writes are in flight.
module tb_reg_wb_sched;
    import reg_wb_pkg::*;

    logic        clk = 1'b0;
    logic        start;
    logic        alu_vld, mem_vld;
    logic [3:0]  alu_addr, mem_addr;
    logic [7:0]  alu_dat, mem_dat;
    logic        alu_rdy, mem_rdy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  dat_in;
    logic [15:0] pend_mask;
    logic        sched_idle;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_wb_sched #(.pw(4), .dw(8)) dut (
        .clk        (clk),
        .start      (start),
        .alu_vld    (alu_vld),
        .alu_addr   (alu_addr),
        .alu_dat    (alu_dat),
        .alu_rdy    (alu_rdy),
        .mem_vld    (mem_vld),
        .mem_addr   (mem_addr),
        .mem_dat    (mem_dat),
        .mem_rdy    (mem_rdy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .dat_in     (dat_in),
        .pend_mask  (pend_mask),
        .sched_idle (sched_idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        alu_vld = 1'b0; mem_vld = 1'b0;
        start = 1'b1;
        tick;
        tick;
        start = 1'b0;
        #1;
    endtask

    task automatic check_wr(input string tag, input logic [3:0] a, input logic [7:0] d);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'(a));
        check({tag, "_dat_in"}, 32'(dat_in), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int a_n, m_n, cnt_a, cnt_m;
        logic acc_a, acc_m;

        start = 1'b1;
        alu_vld = 1'b0; alu_addr = '0; alu_dat = '0;
        mem_vld = 1'b0; mem_addr = '0; mem_dat = '0;
        tick;
        check("start_alu_rdy", 32'(alu_rdy), 0);
        check("start_mem_rdy", 32'(mem_rdy), 0);
        check("start_pend", 32'(pend_mask), 0);
        check("start_idle", 32'(sched_idle), 1);
        check("start_wr_en", 32'(wr_en), 0);

        // Reset state
        do_reset;
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_dat_in", 32'(dat_in), 0);
        check("rst_alu_rdy", 32'(alu_rdy), 1);
        check("rst_mem_rdy", 32'(mem_rdy), 1);
        check("rst_idle", 32'(sched_idle), 1);

        // Single ALU write
        alu_vld = 1'b1; alu_addr = 4'd5; alu_dat = 8'h3C;
        tick;
        alu_vld = 1'b0;
        check("t1_wr_en_acc", 32'(wr_en), 0);
        check("t1_pend_acc", 32'(pend_mask), 32'h0020);
        check("t1_idle_acc", 32'(sched_idle), 0);
        tick;
        check_wr("t1", 4'd5, 8'h3C);
        check("t1_pend_wr", 32'(pend_mask), 32'h0020);
        tick;
        check("t1_wr_en_end", 32'(wr_en), 0);
        check("t1_pend_end", 32'(pend_mask), 0);
        check("t1_idle_end", 32'(sched_idle), 1);

        // Simultaneous, different addresses
        do_reset;
        alu_vld = 1'b1; alu_addr = 4'd1; alu_dat = 8'h11;
        mem_vld = 1'b1; mem_addr = 4'd2; mem_dat = 8'h22;
        tick;
        alu_vld = 1'b0; mem_vld = 1'b0;
        check("t2_pend", 32'(pend_mask), 32'h0006);
        check("t2_alu_rdy", 32'(alu_rdy), 1);
        check("t2_mem_rdy", 32'(mem_rdy), 0);
        tick;
        check_wr("t2a", 4'd1, 8'h11);
        check("t2a_pend", 32'(pend_mask), 32'h0006);
        check("t2a_mem_rdy", 32'(mem_rdy), 1);
        tick;
        check_wr("t2b", 4'd2, 8'h22);
        check("t2b_pend", 32'(pend_mask), 32'h0004);
        tick;
        check("t2_idle", 32'(sched_idle), 1);

        // Same address, MEM accepted first
        do_reset;
        mem_vld = 1'b1; mem_addr = 4'd4; mem_dat = 8'hAA;
        tick;
        mem_vld = 1'b0;
        alu_vld = 1'b1; alu_addr = 4'd4; alu_dat = 8'hBB;
        check("t3_pend", 32'(pend_mask), 32'h0010);
        check("t3_alu_rdy", 32'(alu_rdy), 1);
        tick;
        alu_vld = 1'b0;
        check_wr("t3a", 4'd4, 8'hAA);
        tick;
        check_wr("t3b", 4'd4, 8'hBB);
        tick;
        check("t3_wr_en_end", 32'(wr_en), 0);

        // Same address loaded together while the pointer favours MEM: ALU is older
        do_reset;
        alu_vld = 1'b1; alu_addr = 4'd9; alu_dat = 8'h01;
        tick;
        alu_addr = 4'd4; alu_dat = 8'hBB;
        mem_vld = 1'b1; mem_addr = 4'd4; mem_dat = 8'hAA;
        tick;
        alu_vld = 1'b0; mem_vld = 1'b0;
        check_wr("age0", 4'd9, 8'h01);
        check("age_alu_rdy", 32'(alu_rdy), 1);
        check("age_mem_rdy", 32'(mem_rdy), 0);
        tick;
        check_wr("age1", 4'd4, 8'hBB);
        tick;
        check_wr("age2", 4'd4, 8'hAA);

        // Status register is scheduled like any other
        do_reset;
        alu_vld = 1'b1; alu_addr = 4'(STATUS_ADDR); alu_dat = 8'h5A;
        tick;
        alu_vld = 1'b0;
        check("st_pend", 32'(pend_mask), 32'h0008);
        tick;
        check_wr("st", 4'd3, 8'h5A);

        // Back-pressure with both requesters saturated
        do_reset;
        a_n = 0; m_n = 0; cnt_a = 0; cnt_m = 0;
        alu_vld = 1'b1; alu_addr = 4'd1; alu_dat = 8'h40;
        mem_vld = 1'b1; mem_addr = 4'd2; mem_dat = 8'h80;
        for (int e = 1; e <= 10; e++) begin
            check("bp_mem_rdy", 32'(mem_rdy), 32'(e % 2));
            check("bp_alu_rdy", 32'(alu_rdy), 32'((e == 1) || (e % 2 == 0)));
            acc_a = alu_rdy;
            acc_m = mem_rdy;
            tick;
            if (acc_a) begin a_n++; alu_dat = 8'(8'h40 + a_n); end
            if (acc_m) begin m_n++; mem_dat = 8'(8'h80 + m_n); end
            if (e >= 2) begin
                if (e % 2 == 0) check_wr("bp_alu", 4'd1, 8'(8'h40 + (e / 2 - 1)));
                else            check_wr("bp_mem", 4'd2, 8'(8'h80 + (e - 3) / 2));
                if (wr_en && wr_addr == 4'd1) cnt_a++;
                if (wr_en && wr_addr == 4'd2) cnt_m++;
            end
        end
        alu_vld = 1'b0; mem_vld = 1'b0;
        tick;
        check_wr("bp_mem_last", 4'd2, 8'h84);
        if (wr_en && wr_addr == 4'd1) cnt_a++;
        if (wr_en && wr_addr == 4'd2) cnt_m++;
        check("bp_alu_grants", 32'(cnt_a), 5);
        check("bp_mem_grants", 32'(cnt_m), 5);
        check("bp_alu_accepts", 32'(a_n), 6);
        check("bp_mem_accepts", 32'(m_n), 5);
        tick;
        check_wr("bp_alu_last", 4'd1, 8'h45);
        tick;
        check("bp_idle", 32'(sched_idle), 1);

        // Reset mid-flight
        do_reset;
        alu_vld = 1'b1; alu_addr = 4'd1; alu_dat = 8'h11;
        mem_vld = 1'b1; mem_addr = 4'd2; mem_dat = 8'h22;
        tick;
        mem_vld = 1'b0;
        alu_addr = 4'd3; alu_dat = 8'h33;
        tick;
        alu_vld = 1'b0;
        check_wr("mf_pre", 4'd1, 8'h11);
        check("mf_pend_pre", 32'(pend_mask), 32'h000E);
        start = 1'b1;
        #1;
        check("mf_start_alu_rdy", 32'(alu_rdy), 0);
        check("mf_start_mem_rdy", 32'(mem_rdy), 0);
        check("mf_start_pend", 32'(pend_mask), 0);
        check("mf_start_idle", 32'(sched_idle), 1);
        tick;
        start = 1'b0;
        #1;
        check("mf_wr_en", 32'(wr_en), 0);
        check("mf_pend", 32'(pend_mask), 0);
        check("mf_idle", 32'(sched_idle), 1);
        check("mf_wr_addr", 32'(wr_addr), 0);
        check("mf_dat_in", 32'(dat_in), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("mf_no_stale_wr", 32'(wr_en), 0);
        end
        alu_vld = 1'b1; alu_addr = 4'd6; alu_dat = 8'h66;
        mem_vld = 1'b1; mem_addr = 4'd7; mem_dat = 8'h77;
        tick;
        alu_vld = 1'b0; mem_vld = 1'b0;
        tick;
        check_wr("mf_post_a", 4'd6, 8'h66);
        tick;
        check_wr("mf_post_m", 4'd7, 8'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
